// File: rtl/spi_mem.sv
// SPI-style serial memory: op/address/data frames arrive LSB first on mosi, read data returns on miso.
// Writes commit one cycle after the last data bit; reads announce themselves with a one-cycle ready pulse.
module spi_mem #(
  parameter int         MEM_DEPTH = 32,
  parameter logic [7:0] INIT_VAL  = 8'h00
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic ready,
  output logic op_done
);

  // Addresses are 8 bits on the wire, so MEM_DEPTH is expected to be at most 256.
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    GET_OP,
    GET_ADDR,
    GET_DATA,
    WRITE,
    RD_READY,
    RD_SHIFT
  } state_t;

  state_t     state, state_n;
  logic       op, op_n;
  logic [7:0] addr, addr_n;
  logic [7:0] data, data_n;
  logic [7:0] shreg, shreg_n;
  logic [3:0] cnt, cnt_n;
  logic       miso_n, ready_n, op_done_n;
  logic       mem_we;
  logic       in_range;
  logic [AW-1:0] idx;
  logic [7:0] rd_word;

  logic [7:0] mem [MEM_DEPTH];

  assign in_range = ({24'd0, addr} < MEM_DEPTH);
  assign idx      = addr[AW-1:0];
  assign rd_word  = in_range ? mem[idx] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op      <= 1'b0;
      addr    <= 8'h00;
      data    <= 8'h00;
      shreg   <= 8'h00;
      cnt     <= 4'd0;
      miso    <= 1'b0;
      ready   <= 1'b0;
      op_done <= 1'b0;
    end else begin
      state   <= state_n;
      op      <= op_n;
      addr    <= addr_n;
      data    <= data_n;
      shreg   <= shreg_n;
      cnt     <= cnt_n;
      miso    <= miso_n;
      ready   <= ready_n;
      op_done <= op_done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= INIT_VAL;
    end else if (mem_we) begin
      mem[idx] <= data;
    end
  end

  always_comb begin
    state_n   = state;
    op_n      = op;
    addr_n    = addr;
    data_n    = data;
    shreg_n   = shreg;
    cnt_n     = cnt;
    miso_n    = 1'b0;
    ready_n   = 1'b0;
    op_done_n = 1'b0;
    mem_we    = 1'b0;

    case (state)
      IDLE: begin
        if (!cs) state_n = GET_OP;
      end

      GET_OP: begin
        if (cs) begin
          state_n = IDLE;
        end else begin
          op_n    = mosi;
          cnt_n   = 4'd0;
          state_n = GET_ADDR;
        end
      end

      // cs rising together with the final bit of a phase still completes that phase.
      GET_ADDR: begin
        if (cs && cnt != 4'd7) begin
          cnt_n   = 4'd0;
          state_n = IDLE;
        end else begin
          addr_n = {mosi, addr[7:1]};
          cnt_n  = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n   = 4'd0;
            state_n = op ? GET_DATA : RD_READY;
          end
        end
      end

      GET_DATA: begin
        if (cs && cnt != 4'd7) begin
          cnt_n   = 4'd0;
          state_n = IDLE;
        end else begin
          data_n = {mosi, data[7:1]};
          cnt_n  = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n   = 4'd0;
            state_n = WRITE;
          end
        end
      end

      WRITE: begin
        mem_we    = in_range;
        op_done_n = 1'b1;
        state_n   = IDLE;
      end

      RD_READY: begin
        ready_n = 1'b1;
        shreg_n = rd_word;
        cnt_n   = 4'd0;
        state_n = RD_SHIFT;
      end

      // Eight data cycles, then one extra edge to drop miso and return to IDLE.
      RD_SHIFT: begin
        if (cnt == 4'd8) begin
          cnt_n   = 4'd0;
          state_n = IDLE;
        end else begin
          miso_n  = shreg[0];
          shreg_n = {1'b0, shreg[7:1]};
          cnt_n   = cnt + 4'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_mem.sv
// Bench for spi_mem: per-cycle stimulus queues, captured outputs, and an array model of storage.
module tb_spi_mem;

  localparam int         DEPTH = 32;
  localparam logic [7:0] INIT  = 8'h00;
  localparam int         OBS   = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs = 1'b1;
  logic mosi = 1'b0;
  logic miso, ready, op_done;

  spi_mem #(.MEM_DEPTH(DEPTH), .INIT_VAL(INIT)) dut (
    .clk(clk), .rst(rst), .cs(cs), .mosi(mosi),
    .miso(miso), .ready(ready), .op_done(op_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit rst_q[$];
  bit cs_q[$];
  bit mosi_q[$];
  logic obs_miso[OBS];
  logic obs_ready[OBS];
  logic obs_done[OBS];
  int n_obs = 0;
  logic [7:0] ref_mem [DEPTH];

  task automatic push_idle(input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      rst_q.push_back(r); cs_q.push_back(1'b1); mosi_q.push_back(1'($urandom));
    end
  endtask

  // Tick s is the edge where IDLE sees cs low; op at s+1, address at s+2..s+9, data at s+10..s+17.
  task automatic push_frame(input bit op, input logic [7:0] a, input logic [7:0] d,
                            input bit last_cs_hi, input int tail, output int s);
    logic [15:0] bits;
    int nb;
    bits = {d, a};
    nb = op ? 16 : 8;
    s = cs_q.size();
    rst_q.push_back(1'b0); cs_q.push_back(1'b0); mosi_q.push_back(1'($urandom));
    rst_q.push_back(1'b0); cs_q.push_back(1'b0); mosi_q.push_back(op);
    for (int i = 0; i < nb; i++) begin
      rst_q.push_back(1'b0);
      cs_q.push_back((i == nb - 1) && last_cs_hi);
      mosi_q.push_back(bits[i]);
    end
    push_idle(tail, 1'b0);
  endtask

  task automatic play();
    n_obs = (cs_q.size() < OBS) ? cs_q.size() : OBS;
    for (int k = 0; k < n_obs; k++) begin
      rst = rst_q[k]; cs = cs_q[k]; mosi = mosi_q[k];
      @(posedge clk); #1;
      obs_miso[k] = miso; obs_ready[k] = ready; obs_done[k] = op_done;
    end
    rst_q.delete(); cs_q.delete(); mosi_q.delete();
    rst = 1'b0; cs = 1'b1;
  endtask

  function automatic int count_high(input int sig, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi && k < n_obs; k++) begin
      logic v;
      v = (sig == 0) ? obs_miso[k] : (sig == 1) ? obs_ready[k] : obs_done[k];
      if (v !== 1'b0) c++;
    end
    return c;
  endfunction

  function automatic logic [7:0] byte_at(input int s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = obs_miso[s + i];
    return b;
  endfunction

  // Storage rules: writes land only in range; out-of-range reads return zero.
  function automatic logic [7:0] model(input bit op, input logic [7:0] a, input logic [7:0] d);
    if (op) begin
      if (a < DEPTH) ref_mem[a] = d;
      return 8'h00;
    end
    return (a < DEPTH) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic test_reset();
    int s;
    logic [7:0] e;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT;
    for (int i = 0; i < 3; i++) begin
      rst_q.push_back(1'b1); cs_q.push_back(1'b0); mosi_q.push_back(1'($urandom));
    end
    push_idle(2, 1'b0);
    play();
    n_cmp++; if (count_high(0, 0, n_obs - 1) !== 0) begin n_bad++; $display("FAIL reset_miso: got %0d high cycles, want 0", count_high(0, 0, n_obs - 1)); end
    n_cmp++; if (count_high(1, 0, n_obs - 1) !== 0) begin n_bad++; $display("FAIL reset_ready: got %0d high cycles, want 0", count_high(1, 0, n_obs - 1)); end
    n_cmp++; if (count_high(2, 0, n_obs - 1) !== 0) begin n_bad++; $display("FAIL reset_op_done: got %0d high cycles, want 0", count_high(2, 0, n_obs - 1)); end
    push_frame(1'b0, 8'd7, 8'h00, 1'b0, 10, s);
    e = model(1'b0, 8'd7, 8'h00);
    play();
    n_cmp++; if (byte_at(s + 11) !== e) begin n_bad++; $display("FAIL reset_word7: got %h want %h", byte_at(s + 11), e); end
  endtask

  task automatic test_write_read();
    int s;
    logic [7:0] e;
    push_frame(1'b1, 8'd5, 8'hA5, 1'b0, 3, s);
    e = model(1'b1, 8'd5, 8'hA5);
    play();
    n_cmp++; if (obs_done[s + 18] !== 1'b1) begin n_bad++; $display("FAIL wr_done_timing: got %b at +18, want 1", obs_done[s + 18]); end
    n_cmp++; if (count_high(2, 0, n_obs - 1) !== 1) begin n_bad++; $display("FAIL wr_done_width: got %0d cycles, want 1", count_high(2, 0, n_obs - 1)); end
    push_frame(1'b0, 8'd5, 8'h00, 1'b0, 12, s);
    e = model(1'b0, 8'd5, 8'h00);
    play();
    n_cmp++; if (obs_ready[s + 10] !== 1'b1) begin n_bad++; $display("FAIL rd_ready_timing: got %b at +10, want 1", obs_ready[s + 10]); end
    n_cmp++; if (count_high(1, 0, n_obs - 1) !== 1) begin n_bad++; $display("FAIL rd_ready_width: got %0d cycles, want 1", count_high(1, 0, n_obs - 1)); end
    n_cmp++; if (byte_at(s + 11) !== e || e !== 8'hA5) begin n_bad++; $display("FAIL rd_data_a5: got %h want %h", byte_at(s + 11), 8'hA5); end
    n_cmp++; if (count_high(0, s + 19, n_obs - 1) !== 0 || obs_miso[s + 10] !== 1'b0) begin n_bad++; $display("FAIL rd_miso_idle: got %0d stray high cycles, want 0", count_high(0, s + 19, n_obs - 1)); end
  endtask

  task automatic test_abort();
    int s;
    logic [7:0] a;
    logic [7:0] e;
    a = 8'd3;
    rst_q.push_back(1'b0); cs_q.push_back(1'b0); mosi_q.push_back(1'b0);
    rst_q.push_back(1'b0); cs_q.push_back(1'b0); mosi_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) begin
      rst_q.push_back(1'b0); cs_q.push_back(1'b0); mosi_q.push_back(a[i]);
    end
    push_idle(16, 1'b0);
    play();
    n_cmp++; if (count_high(2, 0, n_obs - 1) !== 0) begin n_bad++; $display("FAIL abort_op_done: got %0d pulses, want 0", count_high(2, 0, n_obs - 1)); end
    n_cmp++; if (count_high(1, 0, n_obs - 1) !== 0) begin n_bad++; $display("FAIL abort_ready: got %0d pulses, want 0", count_high(1, 0, n_obs - 1)); end
    push_frame(1'b0, a, 8'h00, 1'b0, 10, s);
    e = model(1'b0, a, 8'h00);
    play();
    n_cmp++; if (obs_ready[s + 10] !== 1'b1) begin n_bad++; $display("FAIL abort_next_ready: got %b, want 1", obs_ready[s + 10]); end
    n_cmp++; if (byte_at(s + 11) !== e) begin n_bad++; $display("FAIL abort_mem3: got %h want %h", byte_at(s + 11), e); end
  endtask

  task automatic test_out_of_range();
    int s1, s2, s3, s4;
    logic [7:0] e8, e40;
    push_frame(1'b1, 8'd8, 8'h11, 1'b0, 1, s1);
    void'(model(1'b1, 8'd8, 8'h11));
    push_frame(1'b1, 8'd40, 8'hFF, 1'b0, 2, s2);
    void'(model(1'b1, 8'd40, 8'hFF));
    push_frame(1'b0, 8'd8, 8'h00, 1'b0, 10, s3);
    e8 = model(1'b0, 8'd8, 8'h00);
    push_frame(1'b0, 8'd40, 8'h00, 1'b0, 10, s4);
    e40 = model(1'b0, 8'd40, 8'h00);
    play();
    n_cmp++; if (obs_done[s2 + 18] !== 1'b1) begin n_bad++; $display("FAIL oor_wr_done: got %b, want 1", obs_done[s2 + 18]); end
    n_cmp++; if (byte_at(s3 + 11) !== e8) begin n_bad++; $display("FAIL oor_alias_word8: got %h want %h", byte_at(s3 + 11), e8); end
    n_cmp++; if (obs_ready[s4 + 10] !== 1'b1) begin n_bad++; $display("FAIL oor_rd_ready: got %b, want 1", obs_ready[s4 + 10]); end
    n_cmp++; if (byte_at(s4 + 11) !== e40) begin n_bad++; $display("FAIL oor_rd_data: got %h want %h", byte_at(s4 + 11), e40); end
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    logic [7:0] e;
    push_frame(1'b1, 8'd31, 8'h3C, 1'b0, 1, s1);
    void'(model(1'b1, 8'd31, 8'h3C));
    push_frame(1'b0, 8'd31, 8'h00, 1'b0, 10, s2);
    e = model(1'b0, 8'd31, 8'h00);
    play();
    n_cmp++; if (obs_done[s1 + 18] !== 1'b1) begin n_bad++; $display("FAIL b2b_wr_done: got %b, want 1", obs_done[s1 + 18]); end
    n_cmp++; if (obs_ready[s2 + 10] !== 1'b1) begin n_bad++; $display("FAIL b2b_rd_ready: got %b, want 1", obs_ready[s2 + 10]); end
    n_cmp++; if (byte_at(s2 + 11) !== e) begin n_bad++; $display("FAIL b2b_rd_data: got %h want %h", byte_at(s2 + 11), e); end
  endtask

  task automatic test_last_bit_cs();
    int s1, s2;
    logic [7:0] e;
    push_frame(1'b1, 8'd12, 8'h5A, 1'b1, 2, s1);
    void'(model(1'b1, 8'd12, 8'h5A));
    push_frame(1'b0, 8'd12, 8'h00, 1'b1, 10, s2);
    e = model(1'b0, 8'd12, 8'h00);
    play();
    n_cmp++; if (obs_done[s1 + 18] !== 1'b1) begin n_bad++; $display("FAIL lastbit_wr_done: got %b, want 1", obs_done[s1 + 18]); end
    n_cmp++; if (obs_ready[s2 + 10] !== 1'b1) begin n_bad++; $display("FAIL lastbit_rd_ready: got %b, want 1", obs_ready[s2 + 10]); end
    n_cmp++; if (byte_at(s2 + 11) !== e) begin n_bad++; $display("FAIL lastbit_rd_data: got %h want %h", byte_at(s2 + 11), e); end
  endtask

  task automatic test_random();
    int starts[64];
    bit ops[64];
    logic [7:0] exps[64];
    int n_wr, n_rd;
    n_wr = 0; n_rd = 0;
    for (int f = 0; f < 40; f++) begin
      logic [7:0] a, d;
      ops[f] = 1'($urandom);
      a = 8'($urandom_range(0, 39));
      d = 8'($urandom);
      push_frame(ops[f], a, d, 1'($urandom_range(0, 3) == 0),
                 (ops[f] ? 1 : 10) + int'($urandom_range(0, 2)), starts[f]);
      exps[f] = model(ops[f], a, d);
      if (ops[f]) n_wr++; else n_rd++;
    end
    play();
    for (int f = 0; f < 40; f++) begin
      if (ops[f]) begin
        n_cmp++; if (obs_done[starts[f] + 18] !== 1'b1) begin n_bad++; $display("FAIL rand_wr_done[%0d]: got %b, want 1", f, obs_done[starts[f] + 18]); end
      end else begin
        n_cmp++; if (obs_ready[starts[f] + 10] !== 1'b1) begin n_bad++; $display("FAIL rand_rd_ready[%0d]: got %b, want 1", f, obs_ready[starts[f] + 10]); end
        n_cmp++; if (byte_at(starts[f] + 11) !== exps[f]) begin n_bad++; $display("FAIL rand_rd_data[%0d]: got %h want %h", f, byte_at(starts[f] + 11), exps[f]); end
      end
    end
    n_cmp++; if (count_high(2, 0, n_obs - 1) !== n_wr) begin n_bad++; $display("FAIL rand_done_count: got %0d want %0d", count_high(2, 0, n_obs - 1), n_wr); end
    n_cmp++; if (count_high(1, 0, n_obs - 1) !== n_rd) begin n_bad++; $display("FAIL rand_ready_count: got %0d want %0d", count_high(1, 0, n_obs - 1), n_rd); end
  endtask

  task automatic test_reset_mid_read();
    int s0, s;
    int sr[DEPTH];
    push_frame(1'b1, 8'd9, 8'hFF, 1'b0, 1, s0);
    void'(model(1'b1, 8'd9, 8'hFF));
    push_frame(1'b0, 8'd9, 8'h00, 1'b0, 10, s);
    rst_q[s + 14] = 1'b1;
    play();
    n_cmp++; if (obs_miso[s + 13] !== 1'b1) begin n_bad++; $display("FAIL midrst_bit2: got %b, want 1", obs_miso[s + 13]); end
    n_cmp++; if (obs_miso[s + 14] !== 1'b0 || obs_ready[s + 14] !== 1'b0) begin n_bad++; $display("FAIL midrst_outputs: got miso=%b ready=%b, want 0 0", obs_miso[s + 14], obs_ready[s + 14]); end
    n_cmp++; if (count_high(0, s + 14, n_obs - 1) !== 0) begin n_bad++; $display("FAIL midrst_miso_quiet: got %0d high cycles, want 0", count_high(0, s + 14, n_obs - 1)); end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT;
    for (int i = 0; i < DEPTH; i++) push_frame(1'b0, 8'(i), 8'h00, 1'b0, 10, sr[i]);
    play();
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (byte_at(sr[i] + 11) !== model(1'b0, 8'(i), 8'h00)) begin n_bad++; $display("FAIL midrst_word[%0d]: got %h want %h", i, byte_at(sr[i] + 11), INIT); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_abort();
    test_out_of_range();
    test_back_to_back();
    test_last_bit_cs();
    test_random();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
